// File: rtl/jk_pkg.sv
// jk_pkg: JK stage encodings and control struct shared by the counter slice
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef struct packed {
        logic j;
        logic k;
    } jk_ctrl_t;

endpackage

// File: rtl/jk_stage.sv
// jk_stage: single JK flip-flop bit with synchronous active-high reset
module jk_stage
    import jk_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  jk_ctrl_t ctrl,
    output logic     q
);

    logic q_q, q_d;

    always_comb begin
        q_d = ({ctrl.j, ctrl.k} == JK_SET) ? 1'b1 :
              ({ctrl.j, ctrl.k} == JK_CLR) ? 1'b0 :
              ({ctrl.j, ctrl.k} == JK_TOG) ? ~q_q : q_q;
    end

    always_ff @(posedge clk) begin
        q_q <= rst ? 1'b0 : q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: modulo-N up/down counter built from per-bit JK stages
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MODULO < 2 || 2**WIDTH < MODULO) begin : g_bad_params
        $error("jk_updown_counter: need 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_nxt, q_n;
    logic             load_ok, at_end;
    logic             wrap_q, wrap_d, load_err_q, load_err_d;
    jk_ctrl_t         ctrl [WIDTH];

    always_comb begin
        at_end     = up ? (q == MAX) : (q == '0);
        count_nxt  = up ? (at_end ? '0 : q + WIDTH'(1)) : (at_end ? MAX : q - WIDTH'(1));
        load_ok    = 32'(load_val) < MODULO;
        q_n        = load ? (load_ok ? load_val : q) : (en ? count_nxt : q);
        wrap_d     = !load && en && at_end;
        load_err_d = load && !load_ok;
        // Loads drive explicit set/clear so a rejected load rewrites the current value
        for (int i = 0; i < WIDTH; i++) begin
            ctrl[i].j = load ? q_n[i]  : (q_n[i] ^ q[i]);
            ctrl[i].k = load ? ~q_n[i] : (q_n[i] ^ q[i]);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk  (clk),
            .rst  (rst),
            .ctrl (ctrl[i]),
            .q    (q[i])
        );
    end

    always_ff @(posedge clk) begin
        wrap_q     <= rst ? 1'b0 : wrap_d;
        load_err_q <= rst ? 1'b0 : load_err_d;
    end

    assign tc       = at_end;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter: scoreboard bench for modulo-10 and modulo-16 counters
module tb_jk_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q10, q16;
    logic       tc10, tc16, wrap10, wrap16, lerr10, lerr16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic       w;
        logic       e;
        logic       t;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .MODULO(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q10), .tc(tc10), .wrap(wrap10), .load_err(lerr10)
    );

    jk_updown_counter #(.WIDTH(4), .MODULO(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q16), .tc(tc16), .wrap(wrap16), .load_err(lerr16)
    );

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every edge presents a new output sample; compare against the oldest expectation
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.sel ? "q16"    : "q10",    e.sel ? q16    : q10,    e.q);
            check(e.sel ? "wrap16" : "wrap10", {3'b0, e.sel ? wrap16 : wrap10}, {3'b0, e.w});
            check(e.sel ? "lerr16" : "lerr10", {3'b0, e.sel ? lerr16 : lerr10}, {3'b0, e.e});
            check(e.sel ? "tc16"   : "tc10",   {3'b0, e.sel ? tc16   : tc10},   {3'b0, e.t});
        end
    end

    task automatic step(input bit sel, input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] lv,
                        input logic [3:0] xq, input logic xw, input logic xe, input logic xt);
        exp_t x;
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        x.sel = sel; x.q = xq; x.w = xw; x.e = xe; x.t = xt;
        sb.push_back(x);
        #2;
    endtask

    initial begin
        logic [3:0] v;
        // sel  rst en up ld lv    q  w  e  tc
        step(0, 1, 0, 0, 0, 0,     0, 0, 0, 1);
        step(0, 1, 0, 1, 0, 0,     0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            v = 4'(i % 10);
            step(0, 0, 1, 1, 0, 0, v, v == 0, 0, v == 9);
        end
        step(0, 0, 0, 0, 1, 3,     3, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0,     2, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0,     1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0,     0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0,     9, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0,     8, 0, 0, 0);
        step(0, 0, 1, 1, 1, 7,     7, 0, 0, 0);
        step(0, 0, 1, 1, 1, 12,    7, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0,     7, 0, 0, 0);
        step(0, 0, 0, 1, 1, 10,    7, 0, 1, 0);
        step(0, 0, 0, 1, 1, 9,     9, 0, 0, 1);
        step(0, 0, 1, 1, 1, 4,     4, 0, 0, 0);
        step(0, 0, 0, 1, 1, 6,     6, 0, 0, 0);
        step(0, 1, 1, 1, 1, 5,     0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,     1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,     2, 0, 0, 0);
        step(0, 0, 0, 1, 1, 12,    2, 0, 1, 0);
        step(0, 1, 1, 1, 1, 12,    0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0,     9, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0,     0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 15,   15, 0, 0, 1);
        step(1, 0, 1, 1, 0, 0,     0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0,    15, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0,    15, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0,    15, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0,    15, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0,    14, 0, 0, 0);
        step(1, 0, 0, 0, 1, 15,   15, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0,    15, 0, 0, 1);
        en = 0; load = 0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
